// File: rtl/seq_alu.sv
// seq_alu: handshaked WIDTH-bit ALU (add/sub/and in one cycle, iterative shift-add unsigned multiply).
module seq_alu #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             carry,
  output logic             ovf,
  output logic             zero
);
  localparam int CW = $clog2(WIDTH + 1);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state, state_nx;
  logic [2*WIDTH-1:0] acc, acc_nx;
  logic [WIDTH-1:0] mplier, mcand, bb, res_c;
  logic [CW-1:0] cnt;
  logic [WIDTH:0] sum, step_hi;
  logic accept, sub, last;
  assign accept = in_valid && in_ready;
  assign sub = sel == 2'b01;
  assign bb = sub ? ~b : b;
  assign sum = {1'b0, a} + {1'b0, bb} + {{WIDTH{1'b0}}, sub};
  assign res_c = sel[1] ? a & b : sum[WIDTH-1:0];
  // Partial product lands in the upper half with its carry, then the whole accumulator shifts right.
  assign step_hi = {1'b0, acc[2*WIDTH-1:WIDTH]} + (mplier[0] ? {1'b0, mcand} : '0);
  assign acc_nx = {step_hi, acc[WIDTH-1:1]};
  assign last = cnt == CW'(1);
  always_ff @(posedge clk)
    state <= rst ? IDLE : state_nx;
  always_comb begin
    state_nx = IDLE;
    case (state)
      IDLE:    state_nx = accept ? (sel == 2'b11 ? BUSY : DONE) : IDLE;
      BUSY:    state_nx = last ? DONE : BUSY;
      DONE:    state_nx = out_ready ? IDLE : DONE;
      default: state_nx = IDLE;
    endcase
  end
  always_comb begin
    in_ready = state == IDLE;
    out_valid = state == DONE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      result <= '0;
      result_hi <= '0;
      carry <= 1'b0;
      ovf <= 1'b0;
      zero <= 1'b0;
      cnt <= '0;
      acc <= '0;
      mplier <= '0;
      mcand <= '0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          if (sel == 2'b11) begin
            acc <= '0;
            mplier <= b;
            mcand <= a;
            cnt <= CW'(WIDTH);
          end else begin
            result <= res_c;
            result_hi <= '0;
            carry <= !sel[1] && sum[WIDTH];
            ovf <= !sel[1] && (a[WIDTH-1] == bb[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            zero <= ~|res_c;
          end
        end
        BUSY: begin
          acc <= acc_nx;
          mplier <= mplier >> 1;
          cnt <= cnt - 1'b1;
          if (last) begin
            result <= acc_nx[WIDTH-1:0];
            result_hi <= acc_nx[2*WIDTH-1:WIDTH];
            carry <= 1'b0;
            ovf <= |acc_nx[2*WIDTH-1:WIDTH];
            zero <= ~|acc_nx;
          end
        end
        DONE: begin
        end
        default: begin
          result <= '0;
          result_hi <= '0;
          carry <= 1'b0;
          ovf <= 1'b0;
          zero <= 1'b0;
          cnt <= '0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: directed scoreboard bench for seq_alu at WIDTH=8 and WIDTH=16.
module tb_seq_alu;
  typedef struct {
    logic [15:0] lo, hi;
    logic c, o, z;
    int acc, lat;
  } exp_t;
  logic clk = 1'b0, rst = 1'b1;
  int cyc = 0, total = 0, bad = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  logic iv8 = 0, or8 = 1, ir8, ov8, c8, o8, z8, ov8_prev = 0;
  logic [7:0] a8 = 0, b8 = 0, r8, h8;
  logic [1:0] sel8 = 0;
  logic iv16 = 0, or16 = 1, ir16, ov16, c16, o16, z16, ov16_prev = 0;
  logic [15:0] a16 = 0, b16 = 0, r16, h16;
  logic [1:0] sel16 = 0;
  exp_t q8[$], q16[$];
  seq_alu #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8),
    .sel(sel8), .out_valid(ov8), .out_ready(or8), .result(r8), .result_hi(h8), .carry(c8), .ovf(o8), .zero(z8));
  seq_alu #(.WIDTH(16)) dut16 (.clk(clk), .rst(rst), .in_valid(iv16), .in_ready(ir16), .a(a16), .b(b16),
    .sel(sel16), .out_valid(ov16), .out_ready(or16), .result(r16), .result_hi(h16), .carry(c16), .ovf(o16), .zero(z16));
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  function automatic exp_t model(input int w, input longint a, input longint b, input logic [1:0] s, input int acc);
    exp_t e;
    longint m = longint'(1) << w;
    longint half = m / 2;
    longint sa = a >= half ? a - m : a;
    longint sb = b >= half ? b - m : b;
    longint r = 0, hi = 0, ss;
    e.c = 0; e.o = 0; e.acc = acc; e.lat = s == 2'd3 ? w + 1 : 1;
    if (s == 2'd0) begin
      r = a + b; e.c = r >= m; ss = sa + sb; e.o = ss >= half || ss < -half; r = r % m;
    end else if (s == 2'd1) begin
      r = (a - b + m) % m; e.c = a >= b; ss = sa - sb; e.o = ss >= half || ss < -half;
    end else if (s == 2'd2) r = a & b;
    else begin
      r = (a * b) % m; hi = (a * b) / m; e.o = hi != 0;
    end
    e.lo = 16'(r); e.hi = 16'(hi); e.z = r == 0 && hi == 0;
    return e;
  endfunction
  always @(negedge clk) begin
    exp_t e;
    if (ov8 && !ov8_prev) begin
      if (q8.size() == 0) chk("w8_unexpected_output", 64'(ov8), 64'(0));
      else begin
        e = q8.pop_front();
        chk("w8_latency", 64'(cyc - e.acc), 64'(e.lat));
        chk("w8_result", 64'(r8), 64'(e.lo));
        chk("w8_result_hi", 64'(h8), 64'(e.hi));
        chk("w8_flags", 64'({c8, o8, z8}), 64'({e.c, e.o, e.z}));
      end
    end
    ov8_prev = ov8;
  end
  always @(negedge clk) begin
    exp_t e;
    if (ov16 && !ov16_prev) begin
      if (q16.size() == 0) chk("w16_unexpected_output", 64'(ov16), 64'(0));
      else begin
        e = q16.pop_front();
        chk("w16_latency", 64'(cyc - e.acc), 64'(e.lat));
        chk("w16_result", 64'(r16), 64'(e.lo));
        chk("w16_result_hi", 64'(h16), 64'(e.hi));
        chk("w16_flags", 64'({c16, o16, z16}), 64'({e.c, e.o, e.z}));
      end
    end
    ov16_prev = ov16;
  end
  task automatic issue8(input logic [7:0] a, input logic [7:0] b, input logic [1:0] s, output int acc);
    int n = 0;
    a8 = a; b8 = b; sel8 = s; iv8 = 1;
    while (!ir8 && n < 100) begin @(negedge clk); n++; end
    chk("w8_accept_wait", 64'(n < 100), 64'(1));
    acc = cyc;
    q8.push_back(model(8, longint'(a), longint'(b), s, acc));
    @(negedge clk);
    iv8 = 0; a8 = 8'h55; b8 = 8'haa; sel8 = 2'd2;
  endtask
  task automatic issue16(input logic [15:0] a, input logic [15:0] b, input logic [1:0] s);
    int n = 0;
    a16 = a; b16 = b; sel16 = s; iv16 = 1;
    while (!ir16 && n < 100) begin @(negedge clk); n++; end
    chk("w16_accept_wait", 64'(n < 100), 64'(1));
    q16.push_back(model(16, longint'(a), longint'(b), s, cyc));
    @(negedge clk);
    iv16 = 0; a16 = 16'h1234; b16 = 16'h4321;
  endtask
  task automatic drain8();
    int n = 0;
    while (!(ir8 && q8.size() == 0) && n < 200) begin @(negedge clk); n++; end
    chk("w8_drain", 64'(n < 200), 64'(1));
  endtask
  task automatic drain16();
    int n = 0;
    while (!(ir16 && q16.size() == 0) && n < 200) begin @(negedge clk); n++; end
    chk("w16_drain", 64'(n < 200), 64'(1));
  endtask
  initial begin
    int acc, n;
    logic [11:0] snap;
    repeat (2) @(negedge clk);
    rst = 0;
    chk("w8_reset_hs", 64'({ir8, ov8}), 64'(2'b10));
    chk("w8_reset_out", 64'({r8, h8, c8, o8, z8}), 64'(0));
    chk("w16_reset_out", 64'({ir16, ov16, r16, h16, c16, o16, z16}), 64'({1'b1, 36'd0}));
    issue8(8'd200, 8'd100, 2'd0, acc); drain8();
    issue8(8'h7f, 8'h01, 2'd0, acc); drain8();
    issue8(8'd5, 8'd7, 2'd1, acc); drain8();
    issue8(8'd7, 8'd5, 2'd1, acc); drain8();
    issue8(8'h80, 8'h01, 2'd1, acc); drain8();
    issue8(8'hf0, 8'h0f, 2'd2, acc); drain8();
    issue8(8'd15, 8'd17, 2'd3, acc); drain8();
    issue8(8'd200, 8'd3, 2'd3, acc); drain8();
    issue8(8'd0, 8'hff, 2'd3, acc); drain8();
    issue8(8'hff, 8'hff, 2'd3, acc); drain8();
    // Backpressure: result must sit still and a stray in_valid must be ignored.
    or8 = 0;
    issue8(8'd3, 8'd4, 2'd0, acc);
    n = 0;
    while (!ov8 && n < 50) begin @(negedge clk); n++; end
    chk("bp_valid_wait", 64'(n < 50), 64'(1));
    snap = {r8, c8, o8, z8, ir8};
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin a8 = 8'd9; b8 = 8'd9; sel8 = 2'd3; end
      iv8 = i == 2;
      @(negedge clk);
      chk("bp_hold", 64'({ov8, r8, c8, o8, z8, ir8}), 64'({1'b1, snap}));
    end
    iv8 = 0;
    or8 = 1;
    @(negedge clk);
    chk("bp_release", 64'({ir8, ov8}), 64'(2'b10));
    repeat (12) @(negedge clk);
    chk("bp_no_accept", 64'(ir8), 64'(1));
    // Reset four cycles into a multiply discards it entirely.
    issue8(8'd13, 8'd11, 2'd3, acc);
    while (cyc < acc + 4) @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    q8.delete();
    chk("abort_state", 64'({ir8, ov8, r8, h8, c8, o8, z8}), 64'({1'b1, 20'd0}));
    repeat (14) @(negedge clk);
    chk("abort_idle", 64'({ir8, ov8}), 64'(2'b10));
    issue8(8'd10, 8'd20, 2'd0, acc);
    issue8(8'd12, 8'd12, 2'd3, acc);
    issue8(8'd1, 8'd2, 2'd1, acc);
    drain8();
    issue16(16'd15, 16'd17, 2'd3); drain16();
    issue16(16'd200, 16'd3, 2'd3); drain16();
    issue16(16'd0, 16'hffff, 2'd3); drain16();
    issue16(16'hffff, 16'hffff, 2'd3); drain16();
    issue16(16'hffff, 16'h0001, 2'd0); drain16();
    chk("queues_empty", 64'(q8.size() + q16.size()), 64'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
